// File: rtl/drive_mode_controller_pkg.sv
// Shared encodings for the driving-mode sequencer: state codes, mode codes
// and motion command bit positions.
package drive_pkg;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_IDLE   = 3'd1,
        ST_GAP    = 3'd2,
        ST_MANUAL = 3'd3,
        ST_SEMI   = 3'd4,
        ST_AUTO   = 3'd5
    } state_t;

    localparam logic [1:0] MODE_NONE = 2'b00;
    localparam logic [1:0] MODE_MAN  = 2'b01;
    localparam logic [1:0] MODE_SEMI = 2'b10;
    localparam logic [1:0] MODE_AUTO = 2'b11;

    localparam int CMD_FWD   = 3;
    localparam int CMD_BACK  = 2;
    localparam int CMD_LEFT  = 1;
    localparam int CMD_RIGHT = 0;

    function automatic state_t mode_to_state(input logic [1:0] mode);
        case (mode)
            MODE_MAN:  return ST_MANUAL;
            MODE_SEMI: return ST_SEMI;
            MODE_AUTO: return ST_AUTO;
            default:   return ST_IDLE;
        endcase
    endfunction

    function automatic logic [1:0] state_to_mode(input state_t st);
        case (st)
            ST_MANUAL: return MODE_MAN;
            ST_SEMI:   return MODE_SEMI;
            ST_AUTO:   return MODE_AUTO;
            default:   return MODE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/drive_mode_controller_if.sv
// Bus between the driving engines and the mode controller: mode request,
// engine commands, and the granted, sanitized motion command.
interface drive_mode_controller_if;
    logic [1:0] mode_sel;
    logic       vehicle_stopped;
    logic [3:0] man_cmd;
    logic [3:0] semi_cmd;
    logic [3:0] auto_cmd;
    logic [2:0] grant;
    logic [3:0] motor_cmd;

    modport master (
        output mode_sel, vehicle_stopped, man_cmd, semi_cmd, auto_cmd,
        input  grant, motor_cmd
    );

    modport slave (
        input  mode_sel, vehicle_stopped, man_cmd, semi_cmd, auto_cmd,
        output grant, motor_cmd
    );
endinterface

// File: rtl/drive_mode_controller_cmd_sanitizer.sv
// Removes contradictory motion requests: opposing direction pairs that are
// both set are both dropped; other bits pass through.
module cmd_sanitizer
    import drive_pkg::*;
(
    input  logic [3:0] cmd,
    output logic [3:0] clean
);
    always_comb begin
        clean = cmd;
        if (cmd[CMD_FWD] && cmd[CMD_BACK]) begin
            clean[CMD_FWD]  = 1'b0;
            clean[CMD_BACK] = 1'b0;
        end
        if (cmd[CMD_LEFT] && cmd[CMD_RIGHT]) begin
            clean[CMD_LEFT]  = 1'b0;
            clean[CMD_RIGHT] = 1'b0;
        end
    end
endmodule

// File: rtl/drive_mode_controller.sv
// Power sequencing and bus ownership for the manual / semi-auto / auto
// driving engines, with a forced-zero dead gap between owners.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   OFF     | powered down; counting consecutive power_btn high cycles
//   IDLE    | powered, no owner; counting toward idle auto power-off
//   GAP     | dead time before handing the bus to the latched target
//   MANUAL  | manual engine owns the motion bus
//   SEMI    | semi-auto engine owns the motion bus
//   AUTO    | auto engine owns the motion bus
module drive_mode_controller
    import drive_pkg::*;
#(
    parameter int unsigned PWR_HOLD     = 100_000_000,
    parameter int unsigned DEAD_CYCLES  = 4,
    parameter int unsigned IDLE_TIMEOUT = 1_000_000_000,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    power_btn,
    drive_mode_controller_if.slave  bus,
    output logic                    power_on,
    output logic [2:0]              mode_state,
    output logic                    switch_pending
);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [1:0]       target, target_nx;
    logic             btn_prev;
    logic             btn_released, btn_released_nx;
    logic             pending_nx;
    logic [2:0]       grant_r, grant_nx;
    logic [3:0]       motor_r, motor_nx;
    logic [3:0]       owner_cmd, owner_clean;
    logic [1:0]       cur_mode;
    logic             active;
    logic             press;

    assign active   = (state == ST_MANUAL) || (state == ST_SEMI) || (state == ST_AUTO);
    assign cur_mode = state_to_mode(state);
    // A release must be seen while powered before a new press counts, so the
    // power-on hold itself can never immediately power the car back off.
    assign press    = (state != ST_OFF) && power_btn && !btn_prev && btn_released;

    always_comb begin
        case (state)
            ST_MANUAL: owner_cmd = bus.man_cmd;
            ST_SEMI:   owner_cmd = bus.semi_cmd;
            ST_AUTO:   owner_cmd = bus.auto_cmd;
            default:   owner_cmd = 4'b0000;
        endcase
    end

    cmd_sanitizer u_sanitizer (
        .cmd   (owner_cmd),
        .clean (owner_clean)
    );

    always_comb begin
        state_nx        = state;
        cnt_nx          = cnt;
        target_nx       = target;
        pending_nx      = 1'b0;
        btn_released_nx = (state == ST_OFF) ? 1'b0 : (btn_released | ~power_btn);

        if (press) begin
            state_nx = ST_OFF;
            cnt_nx   = '0;
        end else begin
            case (state)
                ST_OFF: begin
                    if (!power_btn) begin
                        cnt_nx = '0;
                    end else if (cnt == CNT_W'(PWR_HOLD - 1)) begin
                        state_nx = ST_IDLE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (bus.mode_sel != MODE_NONE) begin
                        state_nx  = ST_GAP;
                        target_nx = bus.mode_sel;
                        cnt_nx    = '0;
                    end else if (cnt == CNT_W'(IDLE_TIMEOUT - 1)) begin
                        state_nx = ST_OFF;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt == CNT_W'(DEAD_CYCLES - 1)) begin
                        state_nx = mode_to_state(target);
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                ST_MANUAL, ST_SEMI, ST_AUTO: begin
                    cnt_nx = '0;
                    if (bus.mode_sel != cur_mode) begin
                        if (!bus.vehicle_stopped) begin
                            pending_nx = 1'b1;
                        end else if (bus.mode_sel == MODE_NONE) begin
                            state_nx = ST_IDLE;
                        end else begin
                            state_nx  = ST_GAP;
                            target_nx = bus.mode_sel;
                        end
                    end
                end
                default: begin
                    state_nx = ST_OFF;
                    cnt_nx   = '0;
                end
            endcase
        end

        case (state_nx)
            ST_MANUAL: grant_nx = 3'b001;
            ST_SEMI:   grant_nx = 3'b010;
            ST_AUTO:   grant_nx = 3'b100;
            default:   grant_nx = 3'b000;
        endcase

        // Bus is zeroed on the very edge ownership is given up.
        motor_nx = (active && (state_nx == state)) ? owner_clean : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= ST_OFF;
            cnt            <= '0;
            target         <= MODE_NONE;
            btn_prev       <= 1'b0;
            btn_released   <= 1'b0;
            power_on       <= 1'b0;
            grant_r        <= 3'b000;
            motor_r        <= 4'b0000;
            switch_pending <= 1'b0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            target         <= target_nx;
            btn_prev       <= power_btn;
            btn_released   <= btn_released_nx;
            power_on       <= (state_nx != ST_OFF);
            grant_r        <= grant_nx;
            motor_r        <= motor_nx;
            switch_pending <= pending_nx;
        end
    end

    assign mode_state    = state;
    assign bus.grant     = grant_r;
    assign bus.motor_cmd = motor_r;

endmodule

// File: tb/tb_drive_mode_controller.sv
// Bench for drive_mode_controller: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_drive_mode_controller;
    localparam int PH = 5;
    localparam int DC = 4;
    localparam int IT = 10;

    logic       clk;
    logic       rst;
    logic       power_btn;
    logic       power_on;
    logic [2:0] mode_state;
    logic       switch_pending;

    drive_mode_controller_if bus ();

    drive_mode_controller #(
        .PWR_HOLD     (PH),
        .DEAD_CYCLES  (DC),
        .IDLE_TIMEOUT (IT),
        .CNT_W        (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .power_btn      (power_btn),
        .bus            (bus),
        .power_on       (power_on),
        .mode_state     (mode_state),
        .switch_pending (switch_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: phase numbers follow the published state codes;
    // timers are plain counts of elapsed cycles.
    int         m_state  = 0;
    int         m_hold   = 0;
    int         m_idle   = 0;
    int         m_gap    = 0;
    int         m_target = 0;
    bit         m_rel    = 0;
    bit         m_prev   = 0;
    bit         e_pon    = 0;
    bit         e_pend   = 0;
    logic [2:0] e_grant  = 3'b000;
    logic [3:0] e_motor  = 4'b0000;

    function automatic logic [3:0] clean(input logic [3:0] c);
        logic [3:0] r;
        r = c;
        if (c[3:2] == 2'b11) r[3:2] = 2'b00;
        if (c[1:0] == 2'b11) r[1:0] = 2'b00;
        return r;
    endfunction

    always @(posedge clk) begin : model
        int nxt;
        int code;
        int ms;
        logic [3:0] owner;
        ms = int'(bus.mode_sel);
        if (!rst) begin
            m_state = 0; m_hold = 0; m_idle = 0; m_gap = 0; m_target = 0;
            m_rel = 0; m_prev = 0;
            e_pon = 0; e_pend = 0; e_grant = 3'b000; e_motor = 4'b0000;
        end else begin
            nxt = m_state;
            e_pend = 0;
            e_motor = 4'b0000;
            if (m_state != 0 && power_btn && !m_prev && m_rel) begin
                nxt = 0;
                m_hold = 0;
            end else if (m_state == 0) begin
                if (power_btn) begin
                    m_hold++;
                    if (m_hold == PH) begin
                        nxt = 1;
                        m_idle = 0;
                    end
                end else begin
                    m_hold = 0;
                end
            end else if (m_state == 1) begin
                if (ms != 0) begin
                    nxt = 2; m_target = ms; m_gap = DC;
                end else begin
                    m_idle++;
                    if (m_idle == IT) begin
                        nxt = 0;
                        m_hold = 0;
                    end
                end
            end else if (m_state == 2) begin
                m_gap--;
                if (m_gap == 0) nxt = m_target + 2;
            end else begin
                code = m_state - 2;
                if (ms != code) begin
                    if (bus.vehicle_stopped) begin
                        if (ms == 0) begin
                            nxt = 1; m_idle = 0;
                        end else begin
                            nxt = 2; m_target = ms; m_gap = DC;
                        end
                    end else begin
                        e_pend = 1;
                    end
                end
                if (nxt == m_state) begin
                    owner = (code == 1) ? bus.man_cmd : (code == 2) ? bus.semi_cmd : bus.auto_cmd;
                    e_motor = clean(owner);
                end
            end
            m_rel  = (m_state == 0) ? 1'b0 : (m_rel || !power_btn);
            m_prev = power_btn;
            m_state = nxt;
            e_pon = (nxt != 0);
            e_grant = (nxt >= 3) ? 3'(1 << (nxt - 3)) : 3'b000;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_power_on", 8'(power_on), 8'(e_pon));
            chk("model_mode_state", 8'(mode_state), 8'(m_state));
            chk("model_grant", 8'(bus.grant), 8'(e_grant));
            chk("model_motor_cmd", 8'(bus.motor_cmd), 8'(e_motor));
            chk("model_switch_pending", 8'(switch_pending), 8'(e_pend));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int run_left;
        rst = 1'b0; power_btn = 1'b0;
        bus.mode_sel = 2'b00; bus.vehicle_stopped = 1'b1;
        bus.man_cmd = 4'b0000; bus.semi_cmd = 4'b0000; bus.auto_cmd = 4'b0000;
        step(2);
        chk_en = 1'b1;
        chk("reset_power_on", 8'(power_on), 8'h0);
        chk("reset_state", 8'(mode_state), 8'h0);
        chk("reset_grant", 8'(bus.grant), 8'h0);
        chk("reset_motor", 8'(bus.motor_cmd), 8'h0);
        chk("reset_pending", 8'(switch_pending), 8'h0);

        // Power-up: 4 highs then release stays OFF; 5 consecutive powers on.
        rst = 1'b1; power_btn = 1'b1;
        step(4);
        chk("hold4_state", 8'(mode_state), 8'h0);
        power_btn = 1'b0; step(1);
        power_btn = 1'b1; step(4);
        chk("rehold4_power_on", 8'(power_on), 8'h0);
        step(1);
        chk("hold5_power_on", 8'(power_on), 8'h1);
        chk("hold5_state", 8'(mode_state), 8'h1);

        // Manual selection through the dead gap.
        power_btn = 1'b0; bus.mode_sel = 2'b01; bus.man_cmd = 4'b1000;
        for (int i = 0; i < DC; i++) begin
            step(1);
            chk("gap_state", 8'(mode_state), 8'h2);
            chk("gap_grant", 8'(bus.grant), 8'h0);
            chk("gap_motor", 8'(bus.motor_cmd), 8'h0);
        end
        step(1);
        chk("man_grant", 8'(bus.grant), 8'h1);
        chk("man_motor_first", 8'(bus.motor_cmd), 8'h0);
        step(1);
        chk("man_motor", 8'(bus.motor_cmd), 8'h8);

        // Switch blocked while moving, then released into AUTO.
        bus.vehicle_stopped = 1'b0; bus.mode_sel = 2'b11; bus.auto_cmd = 4'b0100;
        step(1);
        chk("blocked_pending", 8'(switch_pending), 8'h1);
        chk("blocked_grant", 8'(bus.grant), 8'h1);
        step(2);
        chk("blocked_motor", 8'(bus.motor_cmd), 8'h8);
        bus.vehicle_stopped = 1'b1;
        step(1);
        chk("unblock_state", 8'(mode_state), 8'h2);
        chk("unblock_pending", 8'(switch_pending), 8'h0);
        chk("unblock_motor", 8'(bus.motor_cmd), 8'h0);
        step(3);
        chk("auto_gap_state", 8'(mode_state), 8'h2);
        step(1);
        chk("auto_grant", 8'(bus.grant), 8'h4);
        step(1);
        chk("auto_motor", 8'(bus.motor_cmd), 8'h4);

        // Sanitizer on the owner path.
        bus.auto_cmd = 4'b1100; step(1);
        chk("san_1100", 8'(bus.motor_cmd), 8'h0);
        bus.auto_cmd = 4'b1011; step(1);
        chk("san_1011", 8'(bus.motor_cmd), 8'h8);
        bus.auto_cmd = 4'b0110; step(1);
        chk("san_0110", 8'(bus.motor_cmd), 8'h6);

        // SEMI, then power-off press with a simultaneous mode request.
        bus.mode_sel = 2'b10; bus.semi_cmd = 4'b0001;
        step(1 + DC);
        chk("semi_state", 8'(mode_state), 8'h4);
        chk("semi_grant", 8'(bus.grant), 8'h2);
        step(1);
        chk("semi_motor", 8'(bus.motor_cmd), 8'h1);
        power_btn = 1'b1; bus.mode_sel = 2'b01;
        step(1);
        chk("poff_power_on", 8'(power_on), 8'h0);
        chk("poff_state", 8'(mode_state), 8'h0);
        chk("poff_grant", 8'(bus.grant), 8'h0);
        chk("poff_motor", 8'(bus.motor_cmd), 8'h0);
        bus.mode_sel = 2'b00;
        step(PH);
        chk("repower_state", 8'(mode_state), 8'h1);

        // Idle timeout: exactly IT cycles in IDLE.
        power_btn = 1'b0;
        step(IT - 1);
        chk("idle_pre_timeout", 8'(mode_state), 8'h1);
        step(1);
        chk("idle_timeout_state", 8'(mode_state), 8'h0);
        chk("idle_timeout_power", 8'(power_on), 8'h0);

        // Reset in the middle of GAP.
        power_btn = 1'b1; step(PH);
        power_btn = 1'b0; bus.mode_sel = 2'b01;
        step(2);
        chk("pre_rst_gap", 8'(mode_state), 8'h2);
        rst = 1'b0; step(1);
        chk("gap_rst_state", 8'(mode_state), 8'h0);
        chk("gap_rst_power", 8'(power_on), 8'h0);
        chk("gap_rst_grant", 8'(bus.grant), 8'h0);
        chk("gap_rst_motor", 8'(bus.motor_cmd), 8'h0);
        rst = 1'b1; bus.mode_sel = 2'b00;

        // Randomized traffic against the model.
        run_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (run_left == 0) begin
                power_btn = ~power_btn;
                run_left = power_btn ? int'($urandom_range(1, 8)) : int'($urandom_range(1, 20));
            end
            run_left--;
            if ($urandom_range(0, 7) == 0) bus.mode_sel = 2'($urandom_range(0, 3));
            bus.vehicle_stopped = ($urandom_range(0, 3) != 0);
            bus.man_cmd  = 4'($urandom_range(0, 15));
            bus.semi_cmd = 4'($urandom_range(0, 15));
            bus.auto_cmd = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 499) != 0);
            step(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/drive_mode_controller.md
Name: drive_mode_controller

Overview:
- Top-level sequencer for the car's driving datapath.
- Owns power-up/power-down and chooses which driving engine (manual, semi-auto, auto) may drive the shared 4-bit motion command bus.
- Enforces a safe changeover: a mode switch happens only when the vehicle is stopped, and a dead gap is inserted between owners.
- Sits between the three driving-mode blocks and the motor/turn output stage.

Parameters:
- PWR_HOLD, 100_000_000: consecutive cycles power_btn must be high in OFF to power on (1 s at 100 MHz).
- DEAD_CYCLES, 4: cycles of forced-zero motion output between owners (≥1).
- IDLE_TIMEOUT, 1_000_000_000: cycles in IDLE with mode_sel==00 before automatic power-off.
- CNT_W, 32: width of the shared timer counter (must hold the largest of the above).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-low reset.
- power_btn  in  1  power button, debounced upstream.
- mode_sel  in  2  requested mode: 00 none, 01 manual, 10 semi-auto, 11 auto.
- vehicle_stopped  in  1  high when the active engine reports zero motion.
- man_cmd  in  4  {fwd, back, left, right} from the manual engine.
- semi_cmd  in  4  same format, from the semi-auto engine.
- auto_cmd  in  4  same format, from the auto engine.
- power_on  out  1  high in every state except OFF.
- grant  out  3  one-hot {auto, semi, manual} ownership; 000 when no owner.
- motor_cmd  out  4  registered, sanitized motion command to the output stage.
- mode_state  out  3  current state encoding.
- switch_pending  out  1  a mode change is requested but blocked because the vehicle is moving.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=OFF; power_on=0, grant=000, motor_cmd=0000, switch_pending=0.
  - Counter cleared; btn_released=0; power_btn history register cleared.
- Reset mid-operation forces OFF on that same edge, regardless of GAP or timer progress.
- States and encodings: OFF=0, IDLE=1, GAP=2, MANUAL=3, SEMI=4, AUTO=5. All outputs are registered.
- OFF:
  - Counter increments while power_btn=1 and clears when power_btn=0.
  - When power_btn=1 and counter==PWR_HOLD-1 → IDLE. power_on rises on the PWR_HOLD-th consecutive high edge.
  - Clear btn_released on entry to IDLE.
- Power-off rule (every powered state):
  - btn_released sets once power_btn is sampled 0.
  - A rising edge of power_btn (previous sample 0, current 1) with btn_released=1 → OFF next edge.
  - Same edge: grant=000, motor_cmd=0000.
  - Power-off has priority over every other transition.
- IDLE:
  - grant=000, motor_cmd=0000.
  - mode_sel≠00 → GAP; latch target=mode_sel; counter cleared.
  - mode_sel==00 → counter increments; at IDLE_TIMEOUT-1 → OFF.
- GAP:
  - grant=000, motor_cmd=0000, counter increments.
  - At DEAD_CYCLES-1 → the latched target state. grant asserts on the edge entering the target.
  - mode_sel changes during GAP are ignored; the target is already latched.
- MANUAL / SEMI / AUTO:
  - grant is the matching one-hot bit.
  - motor_cmd <= sanitized command of the owner (1-cycle latency from the cmd input).
  - Non-owner commands have no effect.
- Sanitizing: fwd&back both 1 → both forced 0. left&right both 1 → both forced 0. Other bits pass through.
- Mode change while in an active mode:
  - mode_sel differs from the current code and vehicle_stopped=1:
    - 00 → IDLE (grant, motor cleared next edge).
    - Otherwise → GAP with the new target latched.
  - vehicle_stopped=0: remain in the current mode, switch_pending=1, owner keeps the bus.
  - switch_pending clears when mode_sel again equals the current code, or when the transition is taken.
- Simultaneous events: power-off press plus mode change on the same edge → OFF wins.

Decomposition:
- Shared package drive_pkg:
  - State encodings.
  - Mode codes MODE_NONE/MAN/SEMI/AUTO.
  - Command bit indices CMD_FWD=3, CMD_BACK=2, CMD_LEFT=1, CMD_RIGHT=0.
- Sub-module: cmd_sanitizer (combinational, 4-in/4-out); one instance is placed after the owner mux.

Test Plan:
- Power-up (PWR_HOLD=5): hold power_btn 4 cycles then release → stays OFF, counter cleared. Hold 5 cycles → power_on=1, mode_state=1.
- Mode selection (DEAD_CYCLES=4): in IDLE set mode_sel=01, man_cmd=1000.
  - grant=000 and motor_cmd=0000 for 4 cycles.
  - Then grant=001; motor_cmd=1000 one cycle after grant.
- Switch blocked while moving: in MANUAL with vehicle_stopped=0, set mode_sel=11.
  - switch_pending=1, grant stays 001.
  - Raise vehicle_stopped → GAP for 4 cycles, then grant=100 with auto_cmd forwarded.
- Sanitizer: owner cmd=1100 → motor_cmd=0000; cmd=1011 → 1000; cmd=0110 → 0110.
- Power-off: in SEMI press power_btn (0→1) after a prior release → next edge power_on=0, grant=000, motor_cmd=0000. Same-edge mode change is ignored.
- Idle timeout and reset:
  - IDLE_TIMEOUT=10, mode_sel=00 → OFF after exactly 10 cycles in IDLE.
  - Separately, assert rst=0 during GAP → all outputs at reset values on that edge.
